// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - loads a frame into the fft core, starts it, streams the N result bins out
// and clears the core between frames.
module fft_frame_sequencer #(
    parameter int width   = 16,
    parameter int M       = 9,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 s_valid,
    input  logic [2*width-1:0]   s_data,
    output logic                 s_ready,
    output logic                 m_valid,
    output logic [2*width-1:0]   m_data,
    output logic [M-1:0]         m_index,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 fft_load,
    output logic [M-1:0]         fft_adr,
    output logic [2*width-1:0]   fft_rd,
    output logic                 fft_start,
    output logic                 fft_reset,
    input  logic [2*width-1:0]   fft_wd,
    input  logic                 fft_done,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [15:0]          frame_count
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam int WTW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [WTW-1:0] WT_LAST = WTW'(RD_LAT - 1);
    localparam logic [M-1:0]   K_LAST  = {M{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        COMPUTE,
        READ_ADR,
        READ_WAIT,
        READ_OUT,
        CLEAR
    } state_t;

    state_t               state_q, state_d;
    logic [M-1:0]         k_q;
    logic [WDW-1:0]       wdog_q;
    logic [WTW-1:0]       wait_q;
    logic                 m_valid_q;
    logic [2*width-1:0]   m_data_q;
    logic [M-1:0]         m_index_q;
    logic                 m_last_q;
    logic                 fft_load_q;
    logic [M-1:0]         fft_adr_q;
    logic [2*width-1:0]   fft_rd_q;
    logic                 fft_start_q;
    logic                 fft_reset_q;
    logic                 busy_q;
    logic                 timeout_err_q;
    logic [15:0]          frame_count_q;
    logic                 beat;

    assign beat = (state_q == LOAD) && s_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (enable) state_d = LOAD;
            LOAD:      if (beat && (k_q == K_LAST)) state_d = START;
            START:     state_d = COMPUTE;
            COMPUTE: begin
                if (fft_done) begin
                    state_d = READ_ADR;
                end else if (wdog_q == WD_LAST) begin
                    state_d = CLEAR;
                end
            end
            READ_ADR:  state_d = READ_WAIT;
            READ_WAIT: if (wait_q == WT_LAST) state_d = READ_OUT;
            READ_OUT:  if (m_ready) state_d = m_last_q ? CLEAR : READ_ADR;
            CLEAR:     state_d = enable ? LOAD : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            k_q           <= '0;
            wdog_q        <= '0;
            wait_q        <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_index_q     <= '0;
            m_last_q      <= 1'b0;
            fft_load_q    <= 1'b0;
            fft_adr_q     <= '0;
            fft_rd_q      <= '0;
            fft_start_q   <= 1'b0;
            fft_reset_q   <= 1'b1;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != IDLE);
            fft_load_q  <= 1'b0;
            fft_start_q <= 1'b0;
            fft_reset_q <= 1'b0;
            case (state_q)
                IDLE: k_q <= '0;
                LOAD: begin
                    if (beat) begin
                        fft_load_q <= 1'b1;
                        fft_adr_q  <= k_q;
                        fft_rd_q   <= s_data;
                        k_q        <= k_q + 1'b1;
                    end
                end
                START: begin
                    fft_start_q <= 1'b1;
                    wdog_q      <= '0;
                end
                COMPUTE: begin
                    // Result address is presented on entry to READ_ADR so the RAM latency
                    // is fully covered by the READ_WAIT cycles.
                    if (fft_done) begin
                        k_q       <= '0;
                        fft_adr_q <= '0;
                    end else if (wdog_q == WD_LAST) begin
                        timeout_err_q <= 1'b1;
                        fft_reset_q   <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                READ_ADR: begin
                    fft_adr_q <= k_q;
                    wait_q    <= '0;
                end
                READ_WAIT: begin
                    if (wait_q == WT_LAST) begin
                        m_data_q  <= fft_wd;
                        m_index_q <= k_q;
                        m_last_q  <= (k_q == K_LAST);
                        m_valid_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                READ_OUT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        if (m_last_q) begin
                            frame_count_q <= frame_count_q + 16'd1;
                            fft_reset_q   <= 1'b1;
                        end else begin
                            k_q       <= k_q + 1'b1;
                            fft_adr_q <= k_q + 1'b1;
                        end
                    end
                end
                CLEAR: k_q <= '0;
                default: k_q <= '0;
            endcase
        end
    end

    assign s_ready     = (state_q == LOAD);
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_index     = m_index_q;
    assign m_last      = m_last_q;
    assign fft_load    = fft_load_q;
    assign fft_adr     = fft_adr_q;
    assign fft_rd      = fft_rd_q;
    assign fft_start   = fft_start_q;
    assign fft_reset   = fft_reset_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - directed bench for fft_frame_sequencer with a behavioural 8-point fft core.
module tb_fft_frame_sequencer;

    localparam int NN = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        m_ready = 1'b1;
    logic [31:0] fft_wd;
    logic        fft_done;
    logic        s_ready, m_valid, m_last, fft_load, fft_start, fft_reset, busy, timeout_err;
    logic [31:0] m_data, fft_rd;
    logic [2:0]  m_index, fft_adr;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    fft_frame_sequencer #(.width(16), .M(3), .RD_LAT(1), .TIMEOUT(20)) dut (
        .clk(clk), .reset(rst_n), .enable(enable),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_index(m_index), .m_last(m_last), .m_ready(m_ready),
        .fft_load(fft_load), .fft_adr(fft_adr), .fft_rd(fft_rd), .fft_start(fft_start),
        .fft_reset(fft_reset), .fft_wd(fft_wd), .fft_done(fft_done),
        .busy(busy), .timeout_err(timeout_err), .frame_count(frame_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural core: exact 8-point DFT with twiddles scaled by 256.
    logic [31:0] mem [NN];
    logic [31:0] res [NN];
    int          dcnt = 0;
    bit          done_en = 1'b1;
    int          c8 [8] = '{256, 181, 0, -181, -256, -181, 0, 181};
    int          s8 [8] = '{0, 181, 256, 181, 0, -181, -256, -181};

    task automatic run_dft();
        for (int k = 0; k < NN; k++) begin
            int re, im;
            re = 0;
            im = 0;
            for (int n = 0; n < NN; n++) begin
                int xr, xi, m;
                xr = int'($signed(mem[n][31:16]));
                xi = int'($signed(mem[n][15:0]));
                m  = (n * k) % NN;
                re += xr * c8[m] + xi * s8[m];
                im += xi * c8[m] - xr * s8[m];
            end
            res[k] = {16'(re >>> 8), 16'(im >>> 8)};
        end
    endtask

    always @(posedge clk) begin
        fft_done <= 1'b0;
        if (fft_load) mem[fft_adr] <= fft_rd;
        if (fft_reset) begin
            dcnt <= 0;
        end else if (fft_start) begin
            run_dft();
            dcnt <= 5;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1 && done_en) fft_done <= 1'b1;
        end
        fft_wd <= res[fft_adr];
    end

    logic [35:0] out_mem [256];
    logic [34:0] load_mem [256];
    int          out_wr = 0, load_wr = 0;
    int          loads_since_clear = 0, starts = 0, bad_start = 0, overlap = 0;
    int          stall_cycles = 0, hold_bad = 0, any_valid = 0;
    bit          prev_stall = 1'b0;
    logic [35:0] prev_word = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            loads_since_clear = 0;
            prev_stall = 1'b0;
        end else begin
            if (fft_load) begin
                loads_since_clear++;
                load_mem[load_wr % 256] = {fft_adr, fft_rd};
                load_wr++;
            end
            if (fft_start) begin
                starts++;
                if (loads_since_clear != NN) bad_start++;
            end
            if (fft_reset) loads_since_clear = 0;
            if (int'(fft_load) + int'(fft_start) + int'(fft_reset) > 1) overlap++;
            if (m_valid) any_valid++;
            if (m_valid && m_ready) begin
                out_mem[out_wr % 256] = {m_last, m_index, m_data};
                out_wr++;
            end
            if (m_valid && !m_ready) begin
                stall_cycles++;
                if (prev_stall && ({m_last, m_index, m_data} != prev_word)) hold_bad++;
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_last, m_index, m_data};
        end
    end

    bit stall_en = 1'b0;
    bit stalled = 1'b0;
    always @(posedge clk) begin
        #1;
        if (stall_en && !stalled && m_valid && m_index == 3'd3) begin
            stalled = 1'b1;
            m_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            m_ready = 1'b1;
        end
    end

    int out_rd = 0, load_rd = 0;

    logic [31:0] imp_in  [8] = '{32'h0010_0000, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] imp_out [8] = '{8{32'h0010_0000}};
    logic [31:0] dc_in   [8] = '{8{32'h0001_0000}};
    logic [31:0] dc_out  [8] = '{32'h0008_0000, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] bp_in   [8] = '{0, 0, 32'h0010_0000, 0, 0, 0, 0, 0};
    logic [31:0] bp_out  [8] = '{32'h0010_0000, 32'h0000_FFF0, 32'hFFF0_0000, 32'h0000_0010,
                                 32'h0010_0000, 32'h0000_FFF0, 32'hFFF0_0000, 32'h0000_0010};
    logic [31:0] zero_in [8] = '{8{32'h0}};

    task automatic sync_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input bit rnd);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 300) begin
            s_data  = d;
            s_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        check_eq("push_accepted", acc, 1);
    endtask

    task automatic push_frame(input logic [31:0] d [8], input bit rnd);
        for (int i = 0; i < NN; i++) push(d[i], rnd);
    endtask

    task automatic expect_frame(input logic [31:0] exp [8]);
        int t;
        t = 0;
        while ((out_wr - out_rd) < NN && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check_eq("frame_complete", (out_wr - out_rd) >= NN, 1);
        for (int i = 0; i < NN; i++) begin
            logic [35:0] w;
            w = out_mem[out_rd % 256];
            out_rd++;
            check_eq("bin_data", w[31:0], exp[i]);
            check_eq("bin_index", w[34:32], i);
            check_eq("bin_last", w[35], (i == NN - 1));
        end
    endtask

    task automatic check_loads(input logic [31:0] d [8]);
        check_eq("load_count", (load_wr - load_rd) >= NN, 1);
        for (int i = 0; i < NN; i++) begin
            logic [34:0] w;
            w = load_mem[load_rd % 256];
            load_rd++;
            check_eq("load_adr", w[34:32], i);
            check_eq("load_data", w[31:0], d[i]);
        end
    endtask

    task automatic wait_clear();
        int t;
        t = 0;
        while (!fft_reset && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq("clear_pulse", fft_reset, 1);
    endtask

    task automatic do_reset();
        enable = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_rd  = out_wr;
        load_rd = load_wr;
    endtask

    initial begin
        int base_starts, base_stall, base_hold, base_valid, base_load, n, t;

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_fft_reset", fft_reset, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_s_ready", s_ready, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_outs", {fft_load, fft_start, m_last, m_data, m_index, fft_adr, fft_rd}, 0);
        check_eq("rst_frame_count", frame_count, 0);
        check_eq("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_fft_reset", fft_reset, 0);
        @(negedge clk);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_s_ready", s_ready, 0);

        // Impulse
        base_starts = starts;
        sync_drive();
        enable = 1'b1;
        push_frame(imp_in, 1'b0);
        expect_frame(imp_out);
        wait_clear();
        check_eq("imp_frame_count", frame_count, 1);
        @(negedge clk);
        check_eq("imp_clear_one_cycle", fft_reset, 0);
        check_eq("imp_starts", starts - base_starts, 1);
        check_loads(imp_in);

        // DC, two back-to-back frames
        do_reset();
        base_starts = starts;
        enable = 1'b1;
        sync_drive();
        push_frame(dc_in, 1'b0);
        push_frame(dc_in, 1'b0);
        expect_frame(dc_out);
        expect_frame(dc_out);
        wait_clear();
        check_eq("dc_frame_count", frame_count, 2);
        check_eq("dc_starts", starts - base_starts, 2);
        check_loads(dc_in);
        check_loads(dc_in);

        // Backpressure on both streams
        do_reset();
        base_stall = stall_cycles;
        base_hold  = hold_bad;
        base_load  = load_wr;
        stall_en   = 1'b1;
        enable     = 1'b1;
        sync_drive();
        push_frame(bp_in, 1'b1);
        expect_frame(bp_out);
        wait_clear();
        check_eq("bp_stall_cycles", stall_cycles - base_stall, 5);
        check_eq("bp_hold", hold_bad - base_hold, 0);
        check_eq("bp_load_total", load_wr - base_load, NN);
        check_loads(bp_in);
        stall_en = 1'b0;

        // Watchdog timeout
        do_reset();
        done_en    = 1'b0;
        base_valid = any_valid;
        enable     = 1'b1;
        sync_drive();
        push_frame(zero_in, 1'b0);
        t = 0;
        while (!fft_start && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("to_start_seen", fft_start, 1);
        n = 0;
        while (!timeout_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("to_cycles", n, 20);
        check_eq("to_clear", fft_reset, 1);
        check_eq("to_frame_count", frame_count, 0);
        check_eq("to_no_output", any_valid - base_valid, 0);
        @(negedge clk);
        check_eq("to_clear_one_cycle", fft_reset, 0);
        check_eq("to_reload", s_ready, 1);
        load_rd = load_wr;
        done_en = 1'b1;
        sync_drive();
        push_frame(imp_in, 1'b0);
        expect_frame(imp_out);
        wait_clear();
        check_eq("to_next_frame_count", frame_count, 1);
        check_eq("to_sticky", timeout_err, 1);

        // Reset during readout
        do_reset();
        enable = 1'b1;
        sync_drive();
        push_frame(imp_in, 1'b0);
        t = 0;
        while (!(m_valid && m_index == 3'd4) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq("mid_reached_bin4", m_valid && m_index == 3'd4, 1);
        #1;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        check_eq("mid_m_valid", m_valid, 0);
        check_eq("mid_outs", {m_data, m_index, m_last, fft_adr, fft_load, fft_start}, 0);
        check_eq("mid_fft_reset", fft_reset, 1);
        check_eq("mid_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_rel_busy", busy, 0);
        check_eq("mid_rel_fft_reset", fft_reset, 0);
        base_valid = any_valid;
        repeat (20) @(negedge clk);
        check_eq("mid_no_partial", any_valid - base_valid, 0);
        check_eq("mid_timeout_cleared", timeout_err, 0);
        out_rd  = out_wr;
        load_rd = load_wr;

        // enable dropped mid-frame parks in IDLE after CLEAR
        enable = 1'b1;
        sync_drive();
        push_frame(dc_in, 1'b0);
        enable = 1'b0;
        expect_frame(dc_out);
        wait_clear();
        check_eq("park_frame_count", frame_count, 1);
        @(negedge clk);
        check_eq("park_busy", busy, 0);
        check_eq("park_s_ready", s_ready, 0);
        repeat (5) @(negedge clk);
        check_eq("park_stays_idle", busy, 0);

        check_eq("no_pin_overlap", overlap, 0);
        check_eq("start_after_n_loads", bad_start, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
